// File: rtl/sound_pkg.sv
// sound_pkg: effect codes, sequencer states and note tables shared by game_sound.
package sound_pkg;
   typedef enum logic [2:0] {FX_NONE, FX_WALL, FX_HIT, FX_GOAL, FX_WIN} effect_t;
   typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;
   localparam logic [15:0] GAP_TICKS = 16'd1000;
   localparam logic [2:0] NOTE_CNT [0:4] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3};
   localparam logic [7:0] NOTE_HALF [0:4][0:2] = '{
      '{8'd0,   8'd0,   8'd0},
      '{8'd227, 8'd0,   8'd0},
      '{8'd114, 8'd0,   8'd0},
      '{8'd114, 8'd227, 8'd0},
      '{8'd95,  8'd76,  8'd64}};
   localparam logic [15:0] NOTE_DUR [0:4][0:2] = '{
      '{16'd0,     16'd0,     16'd0},
      '{16'd5000,  16'd0,     16'd0},
      '{16'd5000,  16'd0,     16'd0},
      '{16'd10000, 16'd20000, 16'd0},
      '{16'd10000, 16'd10000, 16'd30000}};
endpackage

// File: rtl/square_tone.sv
// square_tone: half-period counter and toggle flop; held low and cleared whenever disabled or restarted.
module square_tone (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       en,
   input  logic       restart,
   input  logic [7:0] half,
   output logic       wave
);
   logic [7:0] cnt;
   logic       flip;
   assign flip = cnt == half - 8'd1;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt  <= '0;
         wave <= 1'b0;
      end else if (restart || !en) begin
         cnt  <= '0;
         wave <= 1'b0;
      end else if (tick) begin
         cnt  <= flip ? '0 : cnt + 8'd1;
         wave <= flip ? ~wave : wave;
      end
endmodule

// File: rtl/game_sound.sv
// game_sound: prioritised sound-effect sequencer turning game events into buzzer tones.
module game_sound
   import sound_pkg::*;
#(
   parameter int PRE_DIV = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       hit,
   input  logic       wall,
   input  logic       goal,
   input  logic       p1_win,
   input  logic       p2_win,
   input  logic       mute,
   output logic       buzzer,
   output logic       busy,
   output logic [2:0] effect
);
   localparam int PW = PRE_DIV > 1 ? $clog2(PRE_DIV) : 1;
   state_t        state;
   effect_t       eff, req;
   logic [PW-1:0] pre;
   logic [15:0]   dur, limit;
   logic [1:0]    idx;
   logic          win_q, armed, win_edge, tick, accept, last, done, wave;
   // armed masks the first edge after reset so a win level held through reset never fires
   assign win_edge = (p1_win | p2_win) & ~win_q & armed;
   assign req      = win_edge ? FX_WIN : goal ? FX_GOAL : hit ? FX_HIT : wall ? FX_WALL : FX_NONE;
   assign accept   = req != FX_NONE && req >= eff;
   assign tick     = pre == PW'(PRE_DIV - 1);
   assign last     = {1'b0, idx} == NOTE_CNT[eff] - 3'd1;
   assign limit    = state == GAP ? GAP_TICKS : NOTE_DUR[eff][idx];
   assign done     = tick && dur == limit - 16'd1;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         eff   <= FX_NONE;
         idx   <= '0;
         dur   <= '0;
         pre   <= '0;
         win_q <= 1'b0;
         armed <= 1'b0;
      end else begin
         win_q <= p1_win | p2_win;
         armed <= 1'b1;
         if (accept) begin
            state <= TONE;
            eff   <= req;
            idx   <= '0;
            dur   <= '0;
            pre   <= '0;
         end else if (state != IDLE) begin
            pre <= tick ? '0 : pre + PW'(1);
            dur <= done ? '0 : tick ? dur + 16'd1 : dur;
            if (done) begin
               if (state == GAP) begin
                  state <= TONE;
                  idx   <= idx + 2'd1;
               end else if (last) begin
                  state <= IDLE;
                  eff   <= FX_NONE;
               end else
                  state <= GAP;
            end
         end
      end
   square_tone u_tone (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick),
      .en     (state == TONE),
      .restart(accept),
      .half   (NOTE_HALF[eff][idx]),
      .wave   (wave)
   );
   assign buzzer = wave & (state == TONE) & ~mute;
   assign busy   = state != IDLE;
   assign effect = eff;
endmodule

// File: tb/tb_game_sound.sv
// tb_game_sound: randomized event stimulus checked cycle by cycle against a timeline model of the effects.
module tb_game_sound;
   localparam int P = 2;
   logic clk = 1'b0, rst = 1'b1, hit = 1'b0, wall = 1'b0, goal = 1'b0;
   logic p1_win = 1'b0, p2_win = 1'b0, mute = 1'b0;
   logic buzzer, busy;
   logic [2:0] effect;
   logic rst_v = 1'b1, lvl1 = 1'b0, lvl2 = 1'b0, mu = 1'b0;
   int cmp = 0, bad = 0, cyc = 0;
   int m_e = 0, m_s = 0;
   logic m_prev = 1'b0;
   int half_t [5][3] = '{'{0,0,0}, '{227,0,0}, '{114,0,0}, '{114,227,0}, '{95,76,64}};
   int dur_t  [5][3] = '{'{0,0,0}, '{5000,0,0}, '{5000,0,0}, '{10000,20000,0}, '{10000,10000,30000}};
   int cnt_t  [5]    = '{0, 1, 1, 2, 3};

   game_sound #(.PRE_DIV(P)) dut (
      .clk(clk), .rst(rst), .hit(hit), .wall(wall), .goal(goal),
      .p1_win(p1_win), .p2_win(p2_win), .mute(mute),
      .buzzer(buzzer), .busy(busy), .effect(effect)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      cmp++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
         if (bad >= 50) begin
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
            $finish;
         end
      end
   endtask

   // total effect length in cycles: notes plus the gaps between them
   function automatic int total(input int e);
      int t = 0;
      for (int k = 0; k < cnt_t[e]; k++) t += dur_t[e][k] * P + (k > 0 ? 1000 * P : 0);
      return t;
   endfunction

   // square-wave level t cycles after effect start (0 inside gaps)
   function automatic logic tone(input int e, input int t);
      int o = 0;
      for (int k = 0; k < cnt_t[e]; k++) begin
         if (t >= o && t < o + dur_t[e][k] * P) return ((t - o) / (half_t[e][k] * P)) % 2 == 1;
         o += (dur_t[e][k] + 1000) * P;
      end
      return 1'b0;
   endfunction

   task automatic step(input logic [2:0] pl);
      logic lvl;
      int req;
      @(negedge clk);
      rst = rst_v; {goal, hit, wall} = pl; p1_win = lvl1; p2_win = lvl2; mute = mu;
      @(posedge clk);
      cyc++;
      lvl = lvl1 | lvl2;
      if (rst_v) begin
         m_e = 0;
         m_prev = lvl;
      end else begin
         req = (lvl && !m_prev) ? 4 : pl[2] ? 3 : pl[1] ? 2 : pl[0] ? 1 : 0;
         m_prev = lvl;
         if (req != 0 && req >= m_e) begin
            m_e = req;
            m_s = cyc;
         end else if (m_e != 0 && cyc - m_s >= total(m_e)) m_e = 0;
      end
      #1;
      chk("effect", 32'(effect), 32'(m_e));
      chk("busy", 32'(busy), 32'(m_e != 0));
      chk("buzzer", 32'(buzzer), 32'(m_e != 0 && tone(m_e, cyc - m_s) && !mu));
   endtask

   initial begin
      repeat (3) step(3'b000);
      rst_v = 1'b0;
      repeat (10) step(3'b000);
      step(3'b010);
      repeat (10100) step(3'b000);
      step(3'b001);
      repeat (99) step(3'b000);
      step(3'b010);
      repeat (10050) step(3'b000);
      step(3'b101);
      for (int i = 0; i < 23000; i++)
         step($urandom_range(0, 199) == 0 ? 3'($urandom_range(1, 3)) : 3'b000);
      lvl2 = 1'b1;
      for (int i = 0; i < 22500; i++) begin
         mu = i >= 5000 && i < 9000;
         step($urandom_range(0, 199) == 0 ? 3'($urandom_range(1, 7)) : 3'b000);
      end
      lvl1 = 1'b1;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_effect", 32'(effect), 32'd0);
      chk("async_busy", 32'(busy), 32'd0);
      chk("async_buzzer", 32'(buzzer), 32'd0);
      m_e = 0;
      rst_v = 1'b1;
      repeat (3) step(3'b000);
      rst_v = 1'b0;
      repeat (50) step(3'b000);
      lvl1 = 1'b0;
      lvl2 = 1'b0;
      repeat (5) step(3'b000);
      for (int i = 0; i < 8000; i++) begin
         if ($urandom_range(0, 1999) == 0) lvl1 = ~lvl1;
         if ($urandom_range(0, 499) == 0) mu = ~mu;
         step($urandom_range(0, 299) == 0 ? 3'($urandom_range(1, 7)) : 3'b000);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
      $finish;
   end
endmodule
